// File: rtl/fwd_hazard_unit.sv
// Operand forwarding select and load-use stall detection for an in-order pipeline.
// stall_o is combinational from ID; fwd_sel_o registers alongside the instruction entering EX.
module fwd_hazard_unit #(
    parameter int NUM_SRC   = 2,
    parameter int FWD_DEPTH = 3,
    parameter int LOAD_LAT  = 1,
    localparam int SELW     = $clog2(FWD_DEPTH + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    id_valid_i,
    input  logic [NUM_SRC*5-1:0]    id_rs_addr_i,
    input  logic [NUM_SRC-1:0]      id_rs_used_i,
    input  logic [4:0]              id_rd_addr_i,
    input  logic                    id_rd_wr_en_i,
    input  logic                    id_is_load_i,
    input  logic                    flush_i,
    output logic                    stall_o,
    output logic [NUM_SRC*SELW-1:0] fwd_sel_o,
    output logic [15:0]             stall_cnt_o
);

    typedef struct packed {
        logic       vld;
        logic [4:0] rd;
        logic       wr_en;
        logic       is_load;
    } trk_t;

    trk_t                    ex_q, ex_d;
    trk_t                    slot_q [1:FWD_DEPTH];
    logic [NUM_SRC*SELW-1:0] fwd_sel_q, fwd_sel_d;
    logic [15:0]             stall_cnt_q, stall_cnt_d;
    logic [SELW-1:0]         src_dist [NUM_SRC];
    logic [NUM_SRC-1:0]      src_stall;
    logic                    issue;

    function automatic logic is_prod(input trk_t e, input logic [4:0] a);
        return e.vld && e.wr_en && (e.rd == a) && (a != 5'd0);
    endfunction

    always_comb begin
        for (int j = 0; j < NUM_SRC; j++) begin
            src_dist[j]  = '0;
            src_stall[j] = 1'b0;
            if (id_rs_used_i[j]) begin
                // Scan oldest to youngest so the youngest producer overwrites older hits.
                for (int k = FWD_DEPTH - 1; k >= 1; k--) begin
                    if (is_prod(slot_q[k], id_rs_addr_i[5*j +: 5])) begin
                        src_dist[j]  = SELW'(k + 1);
                        src_stall[j] = slot_q[k].is_load && (k + 1 <= LOAD_LAT);
                    end
                end
                if (is_prod(ex_q, id_rs_addr_i[5*j +: 5])) begin
                    src_dist[j]  = SELW'(1);
                    src_stall[j] = ex_q.is_load && (LOAD_LAT >= 1);
                end
            end
        end
    end

    assign stall_o = id_valid_i && !flush_i && (|src_stall);
    assign issue   = id_valid_i && !stall_o && !flush_i;

    always_comb begin
        ex_d        = '0;
        fwd_sel_d   = '0;
        stall_cnt_d = stall_cnt_q;
        if (issue) begin
            ex_d = '{vld: 1'b1, rd: id_rd_addr_i, wr_en: id_rd_wr_en_i, is_load: id_is_load_i};
            for (int j = 0; j < NUM_SRC; j++) begin
                fwd_sel_d[j*SELW +: SELW] = src_dist[j];
            end
        end
        if (stall_o && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ex_q        <= '0;
            fwd_sel_q   <= '0;
            stall_cnt_q <= '0;
            for (int k = 1; k <= FWD_DEPTH; k++) begin
                slot_q[k] <= '0;
            end
        end else begin
            ex_q        <= ex_d;
            fwd_sel_q   <= fwd_sel_d;
            stall_cnt_q <= stall_cnt_d;
            slot_q[1]   <= ex_q;
            for (int k = 2; k <= FWD_DEPTH; k++) begin
                slot_q[k] <= slot_q[k-1];
            end
        end
    end

    assign fwd_sel_o   = fwd_sel_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: LOAD_LAT=1 and LOAD_LAT=2 instances share ID inputs,
// each tracked by an instruction-history reference model.
module tb_fwd_hazard_unit;

    localparam int FD = 3;

    typedef struct {
        logic       vld;
        logic [4:0] rd;
        logic       wr;
        logic       ld;
    } ment_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [9:0]  id_rs_addr;
    logic [1:0]  id_rs_used;
    logic [4:0]  id_rd;
    logic        id_wr;
    logic        id_ld;
    logic        flush;
    logic        stall_w [2];
    logic [3:0]  sel_w [2];
    logic [15:0] cnt_w [2];

    int          n_tests = 0;
    int          n_fail  = 0;
    int          lat [2];
    ment_t       hist [2][FD];
    ment_t       ms_new [2];
    logic        ms_stall [2];
    logic [3:0]  ms_sel [2];
    logic [3:0]  exp_sel [2];
    logic [15:0] exp_cnt [2];
    logic        stall_seen [2];
    logic [15:0] c0, c1;

    always #5 clk = ~clk;

    fwd_hazard_unit #(.NUM_SRC(2), .FWD_DEPTH(FD), .LOAD_LAT(1)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .id_valid_i(id_valid), .id_rs_addr_i(id_rs_addr),
        .id_rs_used_i(id_rs_used), .id_rd_addr_i(id_rd), .id_rd_wr_en_i(id_wr),
        .id_is_load_i(id_ld), .flush_i(flush), .stall_o(stall_w[0]),
        .fwd_sel_o(sel_w[0]), .stall_cnt_o(cnt_w[0])
    );

    fwd_hazard_unit #(.NUM_SRC(2), .FWD_DEPTH(FD), .LOAD_LAT(2)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .id_valid_i(id_valid), .id_rs_addr_i(id_rs_addr),
        .id_rs_used_i(id_rs_used), .id_rd_addr_i(id_rd), .id_rd_wr_en_i(id_wr),
        .id_is_load_i(id_ld), .flush_i(flush), .stall_o(stall_w[1]),
        .fwd_sel_o(sel_w[1]), .stall_cnt_o(cnt_w[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < FD; i++) hist[m][i] = '{1'b0, 5'd0, 1'b0, 1'b0};
            exp_sel[m] = '0;
            exp_cnt[m] = '0;
        end
    endtask

    // hist[m][i] is the instruction that entered EX i+1 cycles before the next edge,
    // so it sits at forwarding distance i+1 for the instruction now in ID.
    task automatic model_comb(input int m);
        int   d [2];
        logic st;
        logic iss;
        logic [4:0] a;
        st = 1'b0;
        for (int j = 0; j < 2; j++) begin
            d[j] = 0;
            a = id_rs_addr[5*j +: 5];
            if (id_rs_used[j] && a != 5'd0) begin
                for (int i = 0; i < FD; i++) begin
                    if (d[j] == 0 && hist[m][i].vld && hist[m][i].wr && hist[m][i].rd == a) begin
                        d[j] = i + 1;
                        if (hist[m][i].ld && d[j] <= lat[m]) st = 1'b1;
                    end
                end
            end
        end
        st  = st && id_valid && !flush;
        iss = id_valid && !st && !flush;
        ms_stall[m] = st;
        ms_sel[m]   = iss ? {d[1][1:0], d[0][1:0]} : 4'h0;
        ms_new[m]   = iss ? '{1'b1, id_rd, id_wr, id_ld} : '{1'b0, 5'd0, 1'b0, 1'b0};
    endtask

    task automatic model_commit();
        for (int m = 0; m < 2; m++) begin
            if (ms_stall[m] && exp_cnt[m] != 16'hFFFF) exp_cnt[m] = exp_cnt[m] + 16'd1;
            exp_sel[m] = ms_sel[m];
            for (int i = FD - 1; i > 0; i--) hist[m][i] = hist[m][i-1];
            hist[m][0] = ms_new[m];
        end
    endtask

    // Called at a falling edge with ID inputs already driven; returns at the next falling edge.
    task automatic cycle(input string tag);
        #1;
        for (int m = 0; m < 2; m++) begin
            model_comb(m);
            stall_seen[m] = stall_w[m];
            chk($sformatf("%s.stall%0d", tag, m), 32'(stall_w[m]), 32'(ms_stall[m]));
        end
        model_commit();
        @(posedge clk);
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("%s.sel%0d", tag, m), 32'(sel_w[m]), 32'(exp_sel[m]));
            chk($sformatf("%s.cnt%0d", tag, m), 32'(cnt_w[m]), 32'(exp_cnt[m]));
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rd, input logic wr, input logic ld,
                         input logic [4:0] rs0, input logic [4:0] rs1, input logic [1:0] used,
                         input logic fl);
        id_valid   = v;
        id_rd      = rd;
        id_wr      = wr;
        id_ld      = ld;
        id_rs_addr = {rs1, rs0};
        id_rs_used = used;
        flush      = fl;
    endtask

    task automatic idle(input int n);
        drive(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00, 1'b0);
        repeat (n) cycle("idle");
    endtask

    initial begin
        lat[0] = 1;
        lat[1] = 2;
        rst_n  = 1'b0;
        drive(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00, 1'b0);
        model_reset();
        repeat (2) @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("reset.stall%0d", m), 32'(stall_w[m]), 32'd0);
            chk($sformatf("reset.sel%0d", m), 32'(sel_w[m]), 32'd0);
            chk($sformatf("reset.cnt%0d", m), 32'(cnt_w[m]), 32'd0);
        end
        rst_n = 1'b1;

        // ALU back-to-back
        idle(3);
        drive(1'b1, 5'd5, 1'b1, 1'b0, 5'd1, 5'd2, 2'b11, 1'b0); cycle("alu_w");
        drive(1'b1, 5'd6, 1'b1, 1'b0, 5'd5, 5'd1, 2'b11, 1'b0); cycle("alu_r");
        chk("alu.stall", 32'(stall_seen[0]), 32'd0);
        chk("alu.sel", 32'(sel_w[0]), 32'h1);

        // distance 3 then distance 2
        idle(3);
        drive(1'b1, 5'd5, 1'b1, 1'b0, 5'd1, 5'd2, 2'b11, 1'b0);  cycle("d3_w");
        drive(1'b1, 5'd11, 1'b1, 1'b0, 5'd0, 5'd0, 2'b00, 1'b0); cycle("d3_n1");
        drive(1'b1, 5'd12, 1'b1, 1'b0, 5'd0, 5'd0, 2'b00, 1'b0); cycle("d3_n2");
        drive(1'b1, 5'd13, 1'b1, 1'b0, 5'd5, 5'd0, 2'b01, 1'b0); cycle("d3_r");
        chk("dist3.sel", 32'(sel_w[0]), 32'h3);
        idle(3);
        drive(1'b1, 5'd5, 1'b1, 1'b0, 5'd1, 5'd2, 2'b11, 1'b0);  cycle("d2_w");
        drive(1'b1, 5'd11, 1'b1, 1'b0, 5'd0, 5'd0, 2'b00, 1'b0); cycle("d2_n1");
        drive(1'b1, 5'd13, 1'b1, 1'b0, 5'd5, 5'd0, 2'b01, 1'b0); cycle("d2_r");
        chk("dist2.sel", 32'(sel_w[0]), 32'h2);

        // load-use, ID held while stalled
        idle(3);
        c0 = cnt_w[0];
        c1 = cnt_w[1];
        drive(1'b1, 5'd7, 1'b1, 1'b1, 5'd0, 5'd0, 2'b00, 1'b0); cycle("lu_lw");
        drive(1'b1, 5'd8, 1'b1, 1'b0, 5'd7, 5'd7, 2'b11, 1'b0); cycle("lu_1");
        chk("lu.stall_c1_l1", 32'(stall_seen[0]), 32'd1);
        chk("lu.stall_c1_l2", 32'(stall_seen[1]), 32'd1);
        cycle("lu_2");
        chk("lu.stall_c2_l1", 32'(stall_seen[0]), 32'd0);
        chk("lu.sel_l1", 32'(sel_w[0]), 32'hA);
        chk("lu.cnt_l1", 32'(cnt_w[0]), 32'(c0) + 32'd1);
        chk("lu.stall_c2_l2", 32'(stall_seen[1]), 32'd1);
        cycle("lu_3");
        chk("lu.stall_c3_l2", 32'(stall_seen[1]), 32'd0);
        chk("lu.sel_l2", 32'(sel_w[1]), 32'hF);
        chk("lu.cnt_l2", 32'(cnt_w[1]), 32'(c1) + 32'd2);

        // youngest producer wins
        idle(3);
        drive(1'b1, 5'd9, 1'b1, 1'b1, 5'd0, 5'd0, 2'b00, 1'b0);  cycle("yw_lw");
        drive(1'b1, 5'd9, 1'b1, 1'b0, 5'd1, 5'd0, 2'b01, 1'b0);  cycle("yw_addi");
        drive(1'b1, 5'd10, 1'b1, 1'b0, 5'd9, 5'd0, 2'b01, 1'b0); cycle("yw_add");
        chk("yw.stall_l1", 32'(stall_seen[0]), 32'd0);
        chk("yw.stall_l2", 32'(stall_seen[1]), 32'd0);
        chk("yw.sel_l1", 32'(sel_w[0]), 32'h1);
        chk("yw.sel_l2", 32'(sel_w[1]), 32'h1);

        // flush overrides a load-use stall
        idle(3);
        c0 = cnt_w[0];
        drive(1'b1, 5'd7, 1'b1, 1'b1, 5'd0, 5'd0, 2'b00, 1'b0); cycle("fl_lw");
        drive(1'b1, 5'd8, 1'b1, 1'b0, 5'd7, 5'd7, 2'b11, 1'b1); cycle("fl_r");
        chk("flush.stall", 32'(stall_seen[0]), 32'd0);
        chk("flush.sel", 32'(sel_w[0]), 32'd0);
        chk("flush.cnt", 32'(cnt_w[0]), 32'(c0));

        // x0 writer, and unused source against a pending load
        idle(3);
        drive(1'b1, 5'd0, 1'b1, 1'b0, 5'd1, 5'd2, 2'b11, 1'b0); cycle("x0_w");
        drive(1'b1, 5'd3, 1'b1, 1'b0, 5'd0, 5'd0, 2'b11, 1'b0); cycle("x0_r");
        chk("x0.sel", 32'(sel_w[0]), 32'd0);
        idle(3);
        drive(1'b1, 5'd3, 1'b1, 1'b1, 5'd0, 5'd0, 2'b00, 1'b0); cycle("un_lw");
        drive(1'b1, 5'd4, 1'b1, 1'b0, 5'd3, 5'd3, 2'b00, 1'b0); cycle("un_r");
        chk("unused.stall", 32'(stall_seen[0]), 32'd0);
        chk("unused.sel", 32'(sel_w[0]), 32'd0);

        // counter saturation
        idle(3);
        force u_dut0.stall_cnt_q = 16'hFFFE;
        #1;
        release u_dut0.stall_cnt_q;
        exp_cnt[0] = 16'hFFFE;
        chk("sat.preset", 32'(cnt_w[0]), 32'hFFFE);
        drive(1'b1, 5'd7, 1'b1, 1'b1, 5'd0, 5'd0, 2'b00, 1'b0); cycle("sat_lw1");
        drive(1'b1, 5'd8, 1'b1, 1'b0, 5'd7, 5'd0, 2'b01, 1'b0); cycle("sat_s1");
        chk("sat.reach", 32'(cnt_w[0]), 32'hFFFF);
        cycle("sat_go1");
        drive(1'b1, 5'd7, 1'b1, 1'b1, 5'd0, 5'd0, 2'b00, 1'b0); cycle("sat_lw2");
        drive(1'b1, 5'd8, 1'b1, 1'b0, 5'd7, 5'd0, 2'b01, 1'b0); cycle("sat_s2");
        chk("sat.stall", 32'(stall_seen[0]), 32'd1);
        chk("sat.hold", 32'(cnt_w[0]), 32'hFFFF);

        // asynchronous reset in the middle of a stall
        idle(3);
        drive(1'b1, 5'd7, 1'b1, 1'b1, 5'd0, 5'd0, 2'b00, 1'b0); cycle("rs_lw");
        drive(1'b1, 5'd8, 1'b1, 1'b0, 5'd7, 5'd7, 2'b11, 1'b0);
        #1;
        chk("rst.pre_stall", 32'(stall_w[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("rst.stall%0d", m), 32'(stall_w[m]), 32'd0);
            chk($sformatf("rst.sel%0d", m), 32'(sel_w[m]), 32'd0);
            chk($sformatf("rst.cnt%0d", m), 32'(cnt_w[m]), 32'd0);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle("rs_post");
        chk("rst.post_stall", 32'(stall_seen[0]), 32'd0);
        chk("rst.post_sel", 32'(sel_w[0]), 32'd0);

        // randomized traffic over a small register set to provoke hazards
        for (int n = 0; n < 400; n++) begin
            drive(logic'($urandom_range(0, 9) != 0), 5'($urandom_range(0, 3)),
                  logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), logic'($urandom_range(0, 9) == 0));
            cycle("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 SHALL have parameter NUM_SRC, default 2: number of source operands per instruction.
REQ-002 SHALL have parameter FWD_DEPTH, default 3: forwarding stages behind EX (1=EX/MEM, 2=MEM/WB, 3=WB bypass).
REQ-003 SHALL have parameter LOAD_LAT, default 1: a load result is forwardable only from stage k > LOAD_LAT; range 0..FWD_DEPTH-1.
REQ-004 SHALL define SELW = $clog2(FWD_DEPTH+1) locally.
REQ-005 SHALL have port clk_i  in  1: single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_ni  in  1: asynchronous active-low reset.
REQ-007 SHALL have port id_valid_i  in  1: valid instruction in ID.
REQ-008 SHALL have port id_rs_addr_i  in  NUM_SRC*5: source register addresses; source j is bits [5j+4:5j].
REQ-009 SHALL have port id_rs_used_i  in  NUM_SRC: source j is actually read.
REQ-010 SHALL have port id_rd_addr_i  in  5: destination register.
REQ-011 SHALL have port id_rd_wr_en_i  in  1: instruction writes rd.
REQ-012 SHALL have port id_is_load_i  in  1: instruction is a load.
REQ-013 SHALL have port flush_i  in  1: kill the ID instruction (branch redirect resolved in EX).
REQ-014 SHALL have port stall_o  out  1: hold PC and IF/ID; insert bubble into EX.
REQ-015 SHALL have port fwd_sel_o  out  NUM_SRC*SELW: per-source operand select for the instruction in EX; 0 = register file, k = stage k.
REQ-016 SHALL have port stall_cnt_o  out  16: saturating count of stall cycles.

Function
REQ-017 SHALL hold a tracker entry {valid, rd, wr_en, is_load} for EX and for slots 1..FWD_DEPTH.
REQ-018 SHALL shift every cycle: slot[k+1] <= slot[k], slot[1] <= EX entry, and discard slot[FWD_DEPTH].
REQ-019 SHALL load the EX entry from ID when id_valid_i & !stall_o & !flush_i, and with a bubble (valid=0) otherwise.
REQ-020 SHALL treat an entry as a producer for address a only if valid & wr_en & rd == a & a != 0.
REQ-021 SHALL compute, for each used ID source, distance d of the youngest producer as seen next cycle: current EX entry -> d=1; slot k -> d=k+1; d > FWD_DEPTH -> no match.
REQ-022 SHALL let the youngest producer win, with older matches ignored.
REQ-023 SHALL drive stall_o combinationally high when id_valid_i & !flush_i and any used source's youngest producer is a load with d <= LOAD_LAT.
REQ-024 SHALL, on the edge where the EX entry loads from ID, register fwd_sel_o field j = d for a matched used source and 0 otherwise.
REQ-025 SHALL register all fwd_sel_o fields = 0 on any bubble load.
REQ-026 SHALL keep stall_o high across repeated cycles: each bubble ages the load until d > LOAD_LAT, then release stall_o (LOAD_LAT=1 -> exactly one stall cycle).
REQ-027 SHALL let flush_i override stall: stall_o=0, bubble into EX, and stall_cnt_o not incremented.
REQ-028 SHALL increment stall_cnt_o on each cycle with stall_o=1 and saturate at 16'hFFFF.
REQ-029 SHALL give sources with id_rs_used_i=0 fwd_sel=0 and never cause a stall.
REQ-030 SHALL give rd=x0 writers no forwarding and no stall.

Reset
REQ-031 SHALL, while rst_ni=0 (asynchronously), clear all tracker valid bits, fwd_sel_o=0 and stall_cnt_o=0; stall_o is then 0 because no entry is valid.
REQ-032 SHALL, on reset mid-stall, drop stall_o in the same cycle and keep no in-flight producer after release.

Verification
REQ-033 SHALL cover ALU back-to-back: add x5 then sub x6,x5,x1 -> no stall; fwd_sel src0=1, src1=0.
REQ-034 SHALL cover distance 2/3: x5 writer, two unrelated instructions, then reader -> fwd_sel=3; with one unrelated instruction -> fwd_sel=2.
REQ-035 SHALL cover load-use: lw x7 then add x8,x7,x7 -> stall_o=1 for 1 cycle, then both fwd_sel=2, stall_cnt_o=1; with LOAD_LAT=2 -> 2 stall cycles, fwd_sel=3.
REQ-036 SHALL cover youngest-wins: lw x9, addi x9, add x10,x9 -> no stall, fwd_sel=1.
REQ-037 SHALL cover flush during stall: load-use stall plus flush_i=1 -> stall_o=0, bubble into EX with fwd_sel=0, counter unchanged.
REQ-038 SHALL cover x0 and unused: writer rd=x0 followed by reader of x0 -> fwd_sel=0; force counter to 16'hFFFF -> stays 16'hFFFF; assert rst_ni mid-stall -> all outputs 0 immediately.
